tt_vpu_ovi_cmpl_tracker: RTL and testbench

- In-order completion tracker between the vector pipeline commit port and the OVI completion/credit outputs of the VPU wrapper.
- Records the scoreboard ID of every instruction the pipeline accepts from the issue FIFO, in acceptance order.
- On each pipeline commit, pairs that commit with the oldest outstanding ID.
- Drives registered OVI completion fields and returns one issue credit per completed instruction.
- Replaces the single saved-ID register and the tied-off credit.

---
 rtl/tt_vpu_ovi_pkg.sv | 26 ++
 rtl/tt_vpu_id_fifo.sv | 91 +++++++++
 rtl/tt_vpu_ovi_cmpl_tracker.sv | 121 ++++++++++++
 tb/tb_tt_vpu_ovi_cmpl_tracker.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tt_vpu_ovi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tt_vpu_ovi_pkg
// Description : Shared OVI completion types and widths for the VPU wrapper.
// Revision    : 1.0 - initial release
// ============================================================================
package tt_vpu_ovi_pkg;

  localparam int OVI_SB_ID_W  = 5;
  localparam int OVI_VSTART_W = 14;
  localparam int OVI_FFLAGS_W = 5;
  localparam int OVI_DATA_W   = 64;

  // Full OVI completion bundle so the wrapper can drive it from one signal.
  typedef struct packed {
    logic                    valid;
    logic [OVI_SB_ID_W-1:0]  sb_id;
    logic [OVI_FFLAGS_W-1:0] fflags;
    logic [OVI_DATA_W-1:0]   dest_reg;
    logic                    vxsat;
    logic [OVI_VSTART_W-1:0] vstart;
    logic                    illegal;
  } ovi_cmpl_t;

endpackage
`default_nettype wire

// File: rtl/tt_vpu_id_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tt_vpu_id_fifo
// Description : Circular FIFO with wrap-bit pointers, same-cycle push/pop
//               (pop-before-push at full) and sticky overflow/underflow flags.
// Revision    : 1.0 - initial release
// ============================================================================
module tt_vpu_id_fifo #(
  parameter  int WIDTH = 5,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int PW    = AW + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic             pop_ok_o,
  output logic             full_o,
  output logic [PW-1:0]    count_o,
  output logic             err_overflow_o,
  output logic             err_underflow_o
);

  localparam logic [PW-1:0] C_FULL_XOR = {1'b1, {AW{1'b0}}};

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic w_full;
  logic w_empty;
  logic w_push_ok;
  logic w_pop_ok;

  assign w_full  = ((wr_ptr_q ^ rd_ptr_q) == C_FULL_XOR);
  assign w_empty = (wr_ptr_q == rd_ptr_q);

  // A pop frees the head slot in the same cycle, so a push at full is legal
  // whenever a pop is requested (a full FIFO is never empty).
  assign w_pop_ok  = pop_i & ~w_empty;
  assign w_push_ok = push_i & (~w_full | pop_i);

  // Next-state for pointers, occupancy and sticky errors.
  always_comb begin
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, w_push_ok};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, w_pop_ok};
    count_d  = wr_ptr_d - rd_ptr_d;
    ovf_d    = ovf_q | (push_i & w_full & ~pop_i);
    // A same-cycle push never satisfies a pop on an empty FIFO.
    unf_d    = unf_q | (pop_i & w_empty);
  end

  // Pointer, occupancy and error-flag registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Storage array; contents are qualified by the pointers so no reset needed.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
    end
  end

  assign pop_data_o      = mem_q[rd_ptr_q[AW-1:0]];
  assign pop_ok_o        = w_pop_ok;
  assign full_o          = w_full;
  assign count_o         = count_q;
  assign err_overflow_o  = ovf_q;
  assign err_underflow_o = unf_q;

endmodule
`default_nettype wire

// File: rtl/tt_vpu_ovi_cmpl_tracker.sv
`default_nettype none
// ============================================================================
// Module      : tt_vpu_ovi_cmpl_tracker
// Description : In-order pairing of pipeline commits with accepted scoreboard
//               IDs; drives registered OVI completion fields and one issue
//               credit per completed instruction.
// Revision    : 1.0 - initial release
// ============================================================================
module tt_vpu_ovi_cmpl_tracker
  import tt_vpu_ovi_pkg::*;
#(
  parameter  int SB_ID_W = 5,
  parameter  int DEPTH   = 8,
  parameter  int DATA_W  = 64,
  localparam int CW      = $clog2(DEPTH) + 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    accept_valid,
  input  logic [SB_ID_W-1:0]      accept_sb_id,
  output logic                    accept_ready,
  input  logic                    commit_valid,
  input  logic [4:0]              commit_fflags,
  input  logic [DATA_W-1:0]       commit_data,
  input  logic                    commit_vxsat,
  input  logic                    commit_illegal,
  output logic                    completed_valid,
  output logic [SB_ID_W-1:0]      completed_sb_id,
  output logic [4:0]              completed_fflags,
  output logic [DATA_W-1:0]       completed_dest_reg,
  output logic                    completed_vxsat,
  output logic [OVI_VSTART_W-1:0] completed_vstart,
  output logic                    completed_illegal,
  output logic                    issue_credit,
  output logic [CW-1:0]           inflight_count,
  output logic                    err_overflow,
  output logic                    err_underflow
);

  logic [SB_ID_W-1:0] w_head_id;
  logic               w_pop_ok;
  logic               w_full;

  logic               valid_q,   valid_d;
  logic               credit_q,  credit_d;
  logic [SB_ID_W-1:0] sb_id_q,   sb_id_d;
  logic [4:0]         fflags_q,  fflags_d;
  logic [DATA_W-1:0]  dest_q,    dest_d;
  logic               vxsat_q,   vxsat_d;
  logic               illegal_q, illegal_d;

  tt_vpu_id_fifo #(
    .WIDTH (SB_ID_W),
    .DEPTH (DEPTH)
  ) u_id_fifo (
    .clk             (clk),
    .reset_n         (reset_n),
    .push_i          (accept_valid),
    .push_data_i     (accept_sb_id),
    .pop_i           (commit_valid),
    .pop_data_o      (w_head_id),
    .pop_ok_o        (w_pop_ok),
    .full_o          (w_full),
    .count_o         (inflight_count),
    .err_overflow_o  (err_overflow),
    .err_underflow_o (err_underflow)
  );

  // A commit this cycle frees a slot, so the pipeline may push even at full.
  assign accept_ready = ~w_full | commit_valid;

  // Completion stage: strobe/credit follow a valid pop, data fields hold otherwise.
  always_comb begin
    valid_d   = w_pop_ok;
    credit_d  = w_pop_ok;
    sb_id_d   = sb_id_q;
    fflags_d  = fflags_q;
    dest_d    = dest_q;
    vxsat_d   = vxsat_q;
    illegal_d = illegal_q;
    if (w_pop_ok) begin
      sb_id_d   = w_head_id;
      fflags_d  = commit_fflags;
      dest_d    = commit_data;
      vxsat_d   = commit_vxsat;
      illegal_d = commit_illegal;
    end
  end

  // Output register stage; reset discards anything about to complete.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q   <= 1'b0;
      credit_q  <= 1'b0;
      sb_id_q   <= '0;
      fflags_q  <= '0;
      dest_q    <= '0;
      vxsat_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      credit_q  <= credit_d;
      sb_id_q   <= sb_id_d;
      fflags_q  <= fflags_d;
      dest_q    <= dest_d;
      vxsat_q   <= vxsat_d;
      illegal_q <= illegal_d;
    end
  end

  assign completed_valid    = valid_q;
  assign issue_credit       = credit_q;
  assign completed_sb_id    = sb_id_q;
  assign completed_fflags   = fflags_q;
  assign completed_dest_reg = dest_q;
  assign completed_vxsat    = vxsat_q;
  assign completed_illegal  = illegal_q;
  assign completed_vstart   = '0;

endmodule
`default_nettype wire

// File: tb/tb_tt_vpu_ovi_cmpl_tracker.sv
`default_nettype none
// ============================================================================
// Module      : tb_tt_vpu_ovi_cmpl_tracker
// Description : Self-checking bench for the OVI completion tracker.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tt_vpu_ovi_cmpl_tracker;

  localparam int SB_ID_W = 5;
  localparam int DEPTH   = 8;
  localparam int DATA_W  = 64;
  localparam int CW      = $clog2(DEPTH) + 1;

  logic               clk;
  logic               reset_n;
  logic               accept_valid;
  logic [SB_ID_W-1:0] accept_sb_id;
  logic               accept_ready;
  logic               commit_valid;
  logic [4:0]         commit_fflags;
  logic [DATA_W-1:0]  commit_data;
  logic               commit_vxsat;
  logic               commit_illegal;
  logic               completed_valid;
  logic [SB_ID_W-1:0] completed_sb_id;
  logic [4:0]         completed_fflags;
  logic [DATA_W-1:0]  completed_dest_reg;
  logic               completed_vxsat;
  logic [13:0]        completed_vstart;
  logic               completed_illegal;
  logic               issue_credit;
  logic [CW-1:0]      inflight_count;
  logic               err_overflow;
  logic               err_underflow;

  tt_vpu_ovi_cmpl_tracker #(
    .SB_ID_W (SB_ID_W),
    .DEPTH   (DEPTH),
    .DATA_W  (DATA_W)
  ) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .accept_valid       (accept_valid),
    .accept_sb_id       (accept_sb_id),
    .accept_ready       (accept_ready),
    .commit_valid       (commit_valid),
    .commit_fflags      (commit_fflags),
    .commit_data        (commit_data),
    .commit_vxsat       (commit_vxsat),
    .commit_illegal     (commit_illegal),
    .completed_valid    (completed_valid),
    .completed_sb_id    (completed_sb_id),
    .completed_fflags   (completed_fflags),
    .completed_dest_reg (completed_dest_reg),
    .completed_vxsat    (completed_vxsat),
    .completed_vstart   (completed_vstart),
    .completed_illegal  (completed_illegal),
    .issue_credit       (issue_credit),
    .inflight_count     (inflight_count),
    .err_overflow       (err_overflow),
    .err_underflow      (err_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: a queue of outstanding IDs plus the expected output fields.
  logic [SB_ID_W-1:0] mq[$];
  logic               m_valid, m_credit, m_vx, m_il, m_ovf, m_unf;
  logic [SB_ID_W-1:0] m_id;
  logic [4:0]         m_ff;
  logic [DATA_W-1:0]  m_data;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    m_valid = 0; m_credit = 0; m_vx = 0; m_il = 0; m_ovf = 0; m_unf = 0;
    m_id = '0; m_ff = '0; m_data = '0;
  endtask

  task automatic compare_all();
    check("completed_valid",    64'(completed_valid),    64'(m_valid));
    check("issue_credit",       64'(issue_credit),       64'(m_credit));
    check("completed_sb_id",    64'(completed_sb_id),    64'(m_id));
    check("completed_fflags",   64'(completed_fflags),   64'(m_ff));
    check("completed_dest_reg", completed_dest_reg,      m_data);
    check("completed_vxsat",    64'(completed_vxsat),    64'(m_vx));
    check("completed_illegal",  64'(completed_illegal),  64'(m_il));
    check("completed_vstart",   64'(completed_vstart),   64'(0));
    check("inflight_count",     64'(inflight_count),     64'(mq.size()));
    check("err_overflow",       64'(err_overflow),       64'(m_ovf));
    check("err_underflow",      64'(err_underflow),      64'(m_unf));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"},  64'(completed_valid),    64'(0));
    check({tag, "_credit"}, 64'(issue_credit),       64'(0));
    check({tag, "_id"},     64'(completed_sb_id),    64'(0));
    check({tag, "_data"},   completed_dest_reg,      64'(0));
    check({tag, "_ff"},     64'(completed_fflags),   64'(0));
    check({tag, "_count"},  64'(inflight_count),     64'(0));
    check({tag, "_ovf"},    64'(err_overflow),       64'(0));
    check({tag, "_unf"},    64'(err_underflow),      64'(0));
  endtask

  // One clock cycle: called at a negedge, returns at the next negedge.
  task automatic step(input logic av, input logic [SB_ID_W-1:0] id, input logic cv,
                      input logic [4:0] ff, input logic [DATA_W-1:0] d,
                      input logic vx, input logic il);
    bit was_full;
    bit pop;
    accept_valid   = av;
    accept_sb_id   = id;
    commit_valid   = cv;
    commit_fflags  = ff;
    commit_data    = d;
    commit_vxsat   = vx;
    commit_illegal = il;
    #1;
    was_full = (mq.size() == DEPTH);
    check("accept_ready", 64'(accept_ready), 64'(!was_full || cv));
    @(posedge clk);
    pop      = cv && (mq.size() != 0);
    m_valid  = pop;
    m_credit = pop;
    if (cv && mq.size() == 0) m_unf = 1;
    if (av && was_full && !cv) m_ovf = 1;
    if (pop) begin
      m_id   = mq.pop_front();
      m_ff   = ff;
      m_data = d;
      m_vx   = vx;
      m_il   = il;
    end
    if (av && (!was_full || cv)) mq.push_back(id);
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle();
    step(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic push(input logic [SB_ID_W-1:0] id);
    step(1'b1, id, 1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic commit();
    step(1'b0, '0, 1'b1, 5'($urandom), {$urandom, $urandom}, 1'($urandom), 1'($urandom));
  endtask

  // Asynchronous reset asserted in the middle of the high clock phase.
  task automatic async_reset();
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check_all_zero("rst_async");
    model_clear();
    accept_valid = 0; commit_valid = 0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    accept_valid = 0; accept_sb_id = '0; commit_valid = 0;
    commit_fflags = '0; commit_data = '0; commit_vxsat = 0; commit_illegal = 0;
    model_clear();
    repeat (2) @(negedge clk);
    check_all_zero("rst_init");
    check("rst_init_vstart", 64'(completed_vstart), 64'(0));
    reset_n = 1'b1;

    // IDs 3,7,12 then back-to-back commits.
    push(5'd3); push(5'd7); push(5'd12);
    idle(); idle();
    commit();
    check("lit_id0", 64'(completed_sb_id), 64'(3));
    check("lit_cnt0", 64'(inflight_count), 64'(2));
    commit();
    check("lit_id1", 64'(completed_sb_id), 64'(7));
    check("lit_credit1", 64'(issue_credit), 64'(1));
    commit();
    check("lit_id2", 64'(completed_sb_id), 64'(12));
    check("lit_cnt2", 64'(inflight_count), 64'(0));
    idle();
    check("lit_credit_off", 64'(issue_credit), 64'(0));

    // Field capture.
    push(5'd9);
    step(1'b0, '0, 1'b1, 5'h11, 64'hDEAD_BEEF_0000_0001, 1'b1, 1'b0);
    check("lit_ff", 64'(completed_fflags), 64'h11);
    check("lit_data", completed_dest_reg, 64'hDEAD_BEEF_0000_0001);
    check("lit_vx", 64'(completed_vxsat), 64'(1));
    check("lit_vstart", 64'(completed_vstart), 64'(0));
    idle();
    check("lit_hold_data", completed_dest_reg, 64'hDEAD_BEEF_0000_0001);

    // Fill, overflow, then commit at full.
    for (int i = 1; i <= DEPTH; i++) push(SB_ID_W'(i));
    accept_valid = 0; commit_valid = 0;
    #1;
    check("lit_full_ready", 64'(accept_ready), 64'(0));
    push(5'd30);
    check("lit_ovf", 64'(err_overflow), 64'(1));
    check("lit_ovf_cnt", 64'(inflight_count), 64'(8));
    commit_valid = 1;
    #1;
    check("lit_full_ready_commit", 64'(accept_ready), 64'(1));
    commit();
    check("lit_first_out", 64'(completed_sb_id), 64'(1));
    async_reset();

    // Simultaneous push/pop at full.
    for (int i = 1; i <= DEPTH; i++) push(SB_ID_W'(i));
    step(1'b1, 5'd20, 1'b1, 5'h1, 64'h1, 1'b0, 1'b0);
    check("lit_pp_cnt", 64'(inflight_count), 64'(8));
    check("lit_pp_ovf", 64'(err_overflow), 64'(0));
    check("lit_pp_id", 64'(completed_sb_id), 64'(1));
    for (int i = 0; i < DEPTH; i++) commit();
    check("lit_id20", 64'(completed_sb_id), 64'(20));

    // Commit while empty, with and without a same-cycle push.
    commit();
    check("lit_unf_valid", 64'(completed_valid), 64'(0));
    check("lit_unf_credit", 64'(issue_credit), 64'(0));
    check("lit_unf", 64'(err_underflow), 64'(1));
    idle();
    check("lit_unf_held", 64'(err_underflow), 64'(1));
    step(1'b1, 5'd11, 1'b1, '0, '0, 1'b0, 1'b0);
    check("lit_unf_push_valid", 64'(completed_valid), 64'(0));
    check("lit_unf_push_cnt", 64'(inflight_count), 64'(1));
    commit();
    check("lit_id11", 64'(completed_sb_id), 64'(11));

    // Reset with IDs in flight.
    for (int i = 0; i < 5; i++) push(SB_ID_W'(i + 2));
    commit(); commit();
    async_reset();
    check("lit_post_rst_cnt", 64'(inflight_count), 64'(0));
    for (int i = 0; i < 4; i++) idle();
    check("lit_post_rst_valid", 64'(completed_valid), 64'(0));

    // Randomized traffic with varying push/commit bias.
    for (int blk = 0; blk < 15; blk++) begin
      int pa;
      int pc;
      pa = $urandom_range(20, 90);
      pc = $urandom_range(20, 90);
      for (int n = 0; n < 200; n++) begin
        step(1'($urandom_range(0, 99) < pa), 5'($urandom), 1'($urandom_range(0, 99) < pc),
             5'($urandom), {$urandom, $urandom}, 1'($urandom), 1'($urandom));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
